// File: rtl/pwm_update_seq.sv
// pwm_update_seq
//
// Sequencer between the target source and the DSP filter / PWM pair.
// A rising edge on req_in captures a target and runs one start/done transaction
// with the DSP chain. The DSP result is then loaded into the PWM, but only at a
// PWM period boundary, so the output never changes in the middle of a period.
// Requests that arrive while a transaction is in flight are coalesced, and the
// latest target wins. A watchdog flags a DSP chain that never answers.
//
// Optional feature: define PWM_UPDATE_SEQ_SLEW_EN to limit each load to a
// change of at most MAX_STEP. The sequencer then reloads at successive
// boundaries until the result is reached.
//
// Parameters
//   DW       duty-cycle width
//   TW       target word width
//   TIMEOUT  maximum cycles spent waiting for dsp_done (>= 2)
//   MAX_STEP maximum duty change per load (slew build only)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   req_in         update request level; its rising edge triggers an update
//   target_in      target word, sampled on the req_in rising edge
//   dsp_start      one-cycle start pulse to the DSP chain
//   dsp_target     target presented to the DSP chain
//   dsp_done       one-cycle pulse; dsp_value is valid
//   dsp_value      computed duty cycle
//   pwm_period_end one-cycle pulse at the last count of a PWM period
//   pwm_load       one-cycle pulse; the PWM latches pwm_val
//   pwm_val        registered duty value for the PWM
//   busy           high whenever the sequencer is not idle
//   err_timeout    sticky DSP timeout flag, cleared only by rst
//   upd_count      number of completed loads, modulo 256
module pwm_update_seq #(
    parameter int             DW       = 16,
    parameter int             TW       = 32,
    parameter int             TIMEOUT  = 64,
    parameter logic [DW-1:0]  MAX_STEP = 'h0400
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_in,
    input  logic [TW-1:0] target_in,
    output logic          dsp_start,
    output logic [TW-1:0] dsp_target,
    input  logic          dsp_done,
    input  logic [DW-1:0] dsp_value,
    input  logic          pwm_period_end,
    output logic          pwm_load,
    output logic [DW-1:0] pwm_val,
    output logic          busy,
    output logic          err_timeout,
    output logic [7:0]    upd_count
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DSP,
        WAIT_BND,
        LOAD
    } state_t;

    state_t        state;
    logic          req_q;
    logic          req;
    logic          pending;
    logic [TW-1:0] pend_target;
    logic [DW-1:0] result;
    logic [CW-1:0] tmo_cnt;
    logic [DW-1:0] next_val;

    assign req = req_in & ~req_q;

`ifdef PWM_UPDATE_SEQ_SLEW_EN
    // Move cur toward tgt by at most MAX_STEP. Only the magnitude of the
    // difference is compared, so the step can never overshoot or wrap.
    function automatic logic [DW-1:0] slew_step(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] tgt);
        if (tgt > cur)
            return ((tgt - cur) > MAX_STEP) ? (cur + MAX_STEP) : tgt;
        else
            return ((cur - tgt) > MAX_STEP) ? (cur - MAX_STEP) : tgt;
    endfunction

    assign next_val = slew_step(pwm_val, result);
`else
    logic unused_max_step;

    assign unused_max_step = ^MAX_STEP;
    assign next_val        = result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            pending     <= 1'b0;
            pend_target <= '0;
            result      <= '0;
            tmo_cnt     <= '0;
            dsp_start   <= 1'b0;
            dsp_target  <= '0;
            pwm_load    <= 1'b0;
            pwm_val     <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            upd_count   <= '0;
        end else begin
            req_q     <= req_in;
            dsp_start <= 1'b0;
            pwm_load  <= 1'b0;

            case (state)
                IDLE: begin
                    // A fresh edge is newer than anything left pending by a
                    // timeout, so it takes priority.
                    if (req) begin
                        dsp_target <= target_in;
                        pending    <= 1'b0;
                        dsp_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= START;
                    end else if (pending) begin
                        dsp_target <= pend_target;
                        pending    <= 1'b0;
                        dsp_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end

                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_DSP;
                end

                WAIT_DSP: begin
                    // dsp_done beats the watchdog when both land in the final cycle.
                    if (dsp_done) begin
                        result <= dsp_value;
                        state  <= WAIT_BND;
                    end else if (tmo_cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end

                WAIT_BND: begin
                    if (pwm_period_end) begin
                        pwm_load  <= 1'b1;
                        pwm_val   <= next_val;
                        upd_count <= upd_count + 8'd1;
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    if (pending) begin
                        dsp_target <= pend_target;
                        pending    <= 1'b0;
                        dsp_start  <= 1'b1;
                        state      <= START;
`ifdef PWM_UPDATE_SEQ_SLEW_EN
                    end else if (pwm_val != result) begin
                        state <= WAIT_BND;
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Coalescing: later requests overwrite the pending target. This
            // comes after the case so that a request arriving in LOAD survives
            // the pending clear done there.
            if (req && (state != IDLE)) begin
                pending     <= 1'b1;
                pend_target <= target_in;
            end
        end
    end

endmodule

// File: tb/tb_pwm_update_seq.sv
// Directed testbench for pwm_update_seq.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled
// at the same point.
module tb_pwm_update_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_in;
    logic [31:0] target_in;
    logic        dsp_start;
    logic [31:0] dsp_target;
    logic        dsp_done;
    logic [15:0] dsp_value;
    logic        pwm_period_end;
    logic        pwm_load;
    logic [15:0] pwm_val;
    logic        busy;
    logic        err_timeout;
    logic [7:0]  upd_count;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int load_cnt = 0;
    int start_base;
    int load_base;

    pwm_update_seq #(
        .DW(16),
        .TW(32),
        .TIMEOUT(64),
        .MAX_STEP(16'h0400)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_in(req_in),
        .target_in(target_in),
        .dsp_start(dsp_start),
        .dsp_target(dsp_target),
        .dsp_done(dsp_done),
        .dsp_value(dsp_value),
        .pwm_period_end(pwm_period_end),
        .pwm_load(pwm_load),
        .pwm_val(pwm_val),
        .busy(busy),
        .err_timeout(err_timeout),
        .upd_count(upd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dsp_start === 1'b1) start_cnt++;
        if (pwm_load === 1'b1) load_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req_edge(input logic [31:0] t);
        req_in    = 1'b1;
        target_in = t;
        tick();
        req_in    = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] v);
        dsp_done  = 1'b1;
        dsp_value = v;
        tick();
        dsp_done  = 1'b0;
    endtask

    task automatic pulse_pe();
        pwm_period_end = 1'b1;
        tick();
        pwm_period_end = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pwm_val"}, {16'h0, pwm_val}, 32'h0);
        chk({tag, "_dsp_target"}, dsp_target, 32'h0);
        chk({tag, "_upd_count"}, {24'h0, upd_count}, 32'h0);
        chk({tag, "_err"}, {31'h0, err_timeout}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_start"}, {31'h0, dsp_start}, 32'h0);
        chk({tag, "_load"}, {31'h0, pwm_load}, 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        req_in         = 1'b0;
        target_in      = 32'h0;
        dsp_done       = 1'b0;
        dsp_value      = 16'h0;
        pwm_period_end = 1'b0;

        // Reset state
        tick();
        tick();
        chk_all_zero("rst");
        rst = 1'b0;

        // Basic transaction
        req_edge(32'h4995cd80);
        chk("t1_start", {31'h0, dsp_start}, 32'h1);
        chk("t1_target", dsp_target, 32'h4995cd80);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        tick();
        chk("t1_start_off", {31'h0, dsp_start}, 32'h0);
        pulse_done(16'h1234);
        chk("t1_noload", {31'h0, pwm_load}, 32'h0);
        chk("t1_val_hold", {16'h0, pwm_val}, 32'h0);
        pulse_pe();
        chk("t1_load", {31'h0, pwm_load}, 32'h1);
        chk("t1_val", {16'h0, pwm_val}, 32'h1234);
        chk("t1_cnt", {24'h0, upd_count}, 32'h1);
        tick();
        chk("t1_load_off", {31'h0, pwm_load}, 32'h0);
        chk("t1_idle", {31'h0, busy}, 32'h0);

        // dsp_done and pwm_period_end in the same cycle
        req_edge(32'h00000002);
        tick();
        dsp_done       = 1'b1;
        dsp_value      = 16'h5678;
        pwm_period_end = 1'b1;
        tick();
        dsp_done       = 1'b0;
        pwm_period_end = 1'b0;
        chk("t2_noload", {31'h0, pwm_load}, 32'h0);
        chk("t2_val_hold", {16'h0, pwm_val}, 32'h1234);
        tick();
        chk("t2_noload2", {31'h0, pwm_load}, 32'h0);
        pulse_pe();
        chk("t2_load", {31'h0, pwm_load}, 32'h1);
        chk("t2_val", {16'h0, pwm_val}, 32'h5678);
        chk("t2_cnt", {24'h0, upd_count}, 32'h2);
        tick();

        // Coalescing: A, B, C arrive while waiting on the DSP
        start_base = start_cnt;
        req_edge(32'h11111111);
        tick();
        req_edge(32'haaaaaaaa);
        tick();
        req_edge(32'hbbbbbbbb);
        tick();
        req_edge(32'hcccccccc);
        tick();
        chk("t3_target_stable", dsp_target, 32'h11111111);
        pulse_done(16'h0100);
        pulse_pe();
        chk("t3_val1", {16'h0, pwm_val}, 32'h0100);
        tick();
        chk("t3_restart", {31'h0, dsp_start}, 32'h1);
        chk("t3_target_c", dsp_target, 32'hcccccccc);
        tick();
        pulse_done(16'h0200);
        pulse_pe();
        chk("t3_val2", {16'h0, pwm_val}, 32'h0200);
        chk("t3_cnt", {24'h0, upd_count}, 32'h4);
        tick();
        tick();
        tick();
        chk("t3_idle", {31'h0, busy}, 32'h0);
        chk("t3_starts", start_cnt - start_base, 32'd2);

        // Watchdog timeout: 64 cycles in WAIT_DSP without dsp_done
        load_base = load_cnt;
        req_edge(32'h00000004);
        tick();
        repeat (63) tick();
        chk("t4_before_err", {31'h0, err_timeout}, 32'h0);
        chk("t4_before_busy", {31'h0, busy}, 32'h1);
        tick();
        chk("t4_err", {31'h0, err_timeout}, 32'h1);
        chk("t4_idle", {31'h0, busy}, 32'h0);
        chk("t4_val_hold", {16'h0, pwm_val}, 32'h0200);
        chk("t4_noload", load_cnt - load_base, 32'd0);
        req_edge(32'h00000005);
        tick();
        pulse_done(16'h0300);
        pulse_pe();
        chk("t4_val_after", {16'h0, pwm_val}, 32'h0300);
        chk("t4_cnt_after", {24'h0, upd_count}, 32'h5);
        chk("t4_err_sticky", {31'h0, err_timeout}, 32'h1);
        tick();

        // Reset while waiting for the boundary; a boundary pulse arrives together with rst
        load_base = load_cnt;
        req_edge(32'h00000006);
        tick();
        pulse_done(16'h0400);
        rst            = 1'b1;
        pwm_period_end = 1'b1;
        tick();
        rst            = 1'b0;
        pwm_period_end = 1'b0;
        chk_all_zero("t5");
        tick();
        chk("t5_still_idle", {31'h0, busy}, 32'h0);
        chk("t5_noload", load_cnt - load_base, 32'd0);

`ifdef PWM_UPDATE_SEQ_SLEW_EN
        // Slew limiting from 0 toward 0x0A00
        req_edge(32'h00000007);
        tick();
        pulse_done(16'h0A00);
        pulse_pe();
        chk("t6_step1", {16'h0, pwm_val}, 32'h0400);
        tick();
        chk("t6_busy", {31'h0, busy}, 32'h1);
        pulse_pe();
        chk("t6_step2", {16'h0, pwm_val}, 32'h0800);
        tick();
        pulse_pe();
        chk("t6_step3", {16'h0, pwm_val}, 32'h0A00);
        chk("t6_cnt", {24'h0, upd_count}, 32'h3);
        tick();
        chk("t6_idle", {31'h0, busy}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
